simm_bus_initiator: RTL and testbench
=====================================

// Module: simm_bus_initiator
// PURPOSE
// - Bus-cycle initiator for the SIMM controller's processor-side slave interface.
// - Accepts single-word requests (address, size, read/write, write data) on a req/ack handshake.
// - Runs one cs/as/ds/rn_w/byte_selects cycle, stretched by waitstate, and returns read data
//   or a write completion.
// - Serves on-board bus masters that share the SIMM port with the 68030 (memory tester, DMA).
// PARAMETERS
// - ADDR_W       24   request address width; bit BANK_BIT drives bank_addr
// - BANK_BIT     22   address bit selecting SIMM bank
// - TIMEOUT      255  max cycles waitstate may stay high before the cycle aborts with err
// - RECOVER_CYC  2    idle cycles forced between bus cycles (lets controller slot refresh)
// PORTS
// - clock          in   1       system clock, all logic on rising edge
// - reset          in   1       synchronous, active-high
// - req            in   1       request valid; held until ack
// - req_write      in   1       1=write, 0=read
// - req_addr       in   ADDR_W  byte address
// - req_size       in   2       00=long, 01=byte, 10=word, 11=3-byte (rejected)
// - req_wdata      in   32      write data, big-endian lanes (D31:24 = offset 0)
// - ack            out  1       one-cycle pulse: request finished (ok or err)
// - err            out  1       valid with ack: misaligned/illegal size or timeout
// - rdata          out  32      read data, valid with ack on reads; held until next ack
// - cs, as, ds     out  1 each  active-high strobes to simm_controller
// - rn_w           out  1       mirrors req_write (1=write), as the controller expects
// - bank_addr      out  1       req_addr[BANK_BIT]
// - byte_selects   out  4       lane enables, bit3 = D31:24
// - waitstate      in   1       from controller; high = cycle not yet complete
// - data_out       out  32      write data onto memory data bus
// - data_oe        out  1       drive enable for data_out
// - data_in        in   32      memory data bus, read path
// BEHAVIOUR
// - Reset: state IDLE; ack, err, cs, as, ds, data_oe, rn_w, bank_addr = 0;
//   byte_selects = 0; rdata = 0; timeout and recover counters = 0.
// - Lane decode, from size and addr[1:0]:
//   - byte @0..3 -> 1000/0100/0010/0001
//   - word @0 -> 1100, word @2 -> 0011
//   - long @0 -> 1111
//   - all others, and size 11 -> illegal.
// - IDLE: on req with a legal decode, latch request fields and go ADDR.
// - IDLE, illegal decode: no strobes driven; next cycle ack=1, err=1; go RECOVER.
// - ADDR (1 cyc): cs=as=1; rn_w, bank_addr, byte_selects valid; data_oe=req_write. Go DATA.
// - DATA: ds=1 additionally. Clear the timeout counter and go WAIT.
// - WAIT: sample waitstate each cycle; strobes held. First cycle waitstate==0 -> go TERM.
//   - Counter reaches TIMEOUT -> abort: go TERM with err.
// - TERM (1 cyc):
//   - capture data_in into rdata if read and no err;
//   - drop as, ds, cs, data_oe;
//   - ack=1, err as determined; byte_selects -> 0.
// - RECOVER: all strobes low for RECOVER_CYC cycles. req ignored here; then IDLE.
// - Earliest ack is 4 cycles after req accepted: ADDR, DATA, WAIT with waitstate=0, TERM.
// - req held high across ack starts a new cycle only after RECOVER.
//   Requester must drop or change req in the cycle after ack.
// - rn_w, bank_addr, byte_selects never change while as=1.
// - rdata is unchanged on writes and on err.
// - Reset mid-cycle: strobes drop the next cycle, no ack emitted, state IDLE.
// - waitstate is ignored outside WAIT.
// STRUCTURE
// - Shared package maxi030_bus_pkg:
//   - size encodings SIZE_LONG/BYTE/WORD/3B
//   - initiator state encodings IDLE/ADDR/DATA/WAIT/TERM/RECOVER
// - Sub-module byte_lane_decoder: combinational (size, addr[1:0]) -> (byte_selects, illegal).
// - Top holds the FSM, timeout counter, recover counter and the data/rdata registers.
// TESTING
// - Long read, addr 0x000000, waitstate high 3 cycles:
//   cs/as high 6 cycles, ds 5, byte_selects=1111, rn_w=0;
//   rdata=data_in (0xDEADBEEF) with ack; err=0.
// - Word write, addr 0x400002 (bank 1), wdata 0x12345678:
//   byte_selects=0011, bank_addr=1, rn_w=1; data_oe with as; ack, err=0.
// - Byte reads at offsets 0..3: byte_selects 1000,0100,0010,0001 respectively.
// - Word at addr 0x000001, and size=11: no cs/as ever asserted; ack+err after 1 cycle.
// - waitstate stuck high, TIMEOUT=255: strobes drop after 255 WAIT cycles.
//   ack+err; rdata keeps prior value.
// - Back-to-back: req held through ack -> exactly RECOVER_CYC all-low cycles before next as.
//   Reset asserted during WAIT -> strobes 0 the next cycle, no ack.

Source files
------------

// File: rtl/maxi030_bus_pkg.sv
// rtl/maxi030_bus_pkg.sv - shared size and initiator state encodings for the SIMM bus
package maxi030_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_LONG = 2'b00,
    SIZE_BYTE = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_3B   = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    WAIT    = 3'd3,
    TERM    = 3'd4,
    RECOVER = 3'd5
  } init_state_e;

endpackage

// File: rtl/byte_lane_decoder.sv
// rtl/byte_lane_decoder.sv - size/offset to big-endian lane enables with illegal flag
module byte_lane_decoder
  import maxi030_bus_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] byte_selects_o,
  output logic       illegal_o
);

  // Lane bit3 is D31:24 (offset 0); anything not naturally aligned is illegal
  always_comb begin
    byte_selects_o = 4'b0000;
    illegal_o      = 1'b1;
    case (size_i)
      SIZE_BYTE: begin
        byte_selects_o = 4'b1000 >> addr_i;
        illegal_o      = 1'b0;
      end
      SIZE_WORD: begin
        if (addr_i == 2'b00) begin
          byte_selects_o = 4'b1100;
          illegal_o      = 1'b0;
        end else if (addr_i == 2'b10) begin
          byte_selects_o = 4'b0011;
          illegal_o      = 1'b0;
        end
      end
      SIZE_LONG: begin
        if (addr_i == 2'b00) begin
          byte_selects_o = 4'b1111;
          illegal_o      = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/simm_bus_initiator.sv
// rtl/simm_bus_initiator.sv - single-word bus-cycle initiator for the SIMM slave port
module simm_bus_initiator
  import maxi030_bus_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int BANK_BIT    = 22,
  parameter int TIMEOUT     = 255,
  parameter int RECOVER_CYC = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              ack,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              cs,
  output logic              as,
  output logic              ds,
  output logic              rn_w,
  output logic              bank_addr,
  output logic [3:0]        byte_selects,
  input  logic              waitstate,
  output logic [31:0]       data_out,
  output logic              data_oe,
  input  logic [31:0]       data_in
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int RC_W = $clog2(RECOVER_CYC + 1);

  init_state_e      state_q, state_d;
  logic             write_q, write_d;
  logic             bank_q, bank_d;
  logic [3:0]       bs_q, bs_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [RC_W-1:0]  rc_cnt_q, rc_cnt_d;

  logic [3:0]       dec_bs;
  logic             dec_illegal;
  logic             unused_addr;

  assign unused_addr = ^req_addr;

  byte_lane_decoder u_decoder (
    .size_i         (req_size),
    .addr_i         (req_addr[1:0]),
    .byte_selects_o (dec_bs),
    .illegal_o      (dec_illegal)
  );

  assign data_out = wdata_q;
  assign rdata    = rdata_q;

  // Next-state and strobe decode; strobes are a pure function of state so they drop
  // the cycle after reset. The RECOVER dwell plus the IDLE accept cycle together give
  // RECOVER_CYC all-low cycles between an ack and the next address strobe.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    bank_d       = bank_q;
    bs_d         = bs_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    to_cnt_d     = to_cnt_q;
    rc_cnt_d     = rc_cnt_q;
    ack          = 1'b0;
    err          = 1'b0;
    cs           = 1'b0;
    as           = 1'b0;
    ds           = 1'b0;
    rn_w         = 1'b0;
    bank_addr    = 1'b0;
    byte_selects = 4'b0000;
    data_oe      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (dec_illegal) begin
            err_d   = 1'b1;
            state_d = TERM;
          end else begin
            write_d = req_write;
            bank_d  = req_addr[BANK_BIT];
            bs_d    = dec_bs;
            wdata_d = req_wdata;
            err_d   = 1'b0;
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        cs           = 1'b1;
        as           = 1'b1;
        rn_w         = write_q;
        bank_addr    = bank_q;
        byte_selects = bs_q;
        data_oe      = write_q;
        state_d      = DATA;
      end
      DATA: begin
        cs           = 1'b1;
        as           = 1'b1;
        ds           = 1'b1;
        rn_w         = write_q;
        bank_addr    = bank_q;
        byte_selects = bs_q;
        data_oe      = write_q;
        to_cnt_d     = '0;
        state_d      = WAIT;
      end
      WAIT: begin
        cs           = 1'b1;
        as           = 1'b1;
        ds           = 1'b1;
        rn_w         = write_q;
        bank_addr    = bank_q;
        byte_selects = bs_q;
        data_oe      = write_q;
        if (!waitstate) begin
          // Read data is valid on the bus in the cycle the controller releases waitstate
          if (!write_q) rdata_d = data_in;
          state_d = TERM;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = TERM;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      TERM: begin
        ack      = 1'b1;
        err      = err_q;
        rc_cnt_d = '0;
        state_d  = RECOVER;
      end
      RECOVER: begin
        if (rc_cnt_q == RC_W'(RECOVER_CYC - 2)) begin
          state_d = IDLE;
        end else begin
          rc_cnt_d = rc_cnt_q + RC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      bank_q   <= 1'b0;
      bs_q     <= 4'b0000;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      to_cnt_q <= '0;
      rc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      bank_q   <= bank_d;
      bs_q     <= bs_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      to_cnt_q <= to_cnt_d;
      rc_cnt_q <= rc_cnt_d;
    end
  end

endmodule

// File: tb/tb_simm_bus_initiator.sv
// tb/tb_simm_bus_initiator.sv - directed self-checking bench for simm_bus_initiator
module tb_simm_bus_initiator;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic        req_write;
  logic [23:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic        cs;
  logic        as;
  logic        ds;
  logic        rn_w;
  logic        bank_addr;
  logic [3:0]  byte_selects;
  logic        waitstate;
  logic [31:0] data_out;
  logic        data_oe;
  logic [31:0] data_in;

  int checks   = 0;
  int failures = 0;

  simm_bus_initiator #(
    .ADDR_W      (24),
    .BANK_BIT    (22),
    .TIMEOUT     (255),
    .RECOVER_CYC (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_wdata    (req_wdata),
    .ack          (ack),
    .err          (err),
    .rdata        (rdata),
    .cs           (cs),
    .as           (as),
    .ds           (ds),
    .rn_w         (rn_w),
    .bank_addr    (bank_addr),
    .byte_selects (byte_selects),
    .waitstate    (waitstate),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .data_in      (data_in)
  );

  always #5 clock = ~clock;

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Issues one request and observes the bus until ack (bounded); returns what it saw
  task automatic run_txn(input logic w, input logic [23:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input int ws_high, input bit hold,
                         output int n_as, output int n_ds, output int n_cs, output int lat,
                         output logic got_err, output logic [3:0] bs_seen,
                         output logic rnw_seen, output logic bank_seen,
                         output int bad_oe, output int unstable);
    n_as = 0; n_ds = 0; n_cs = 0; lat = -1; got_err = 1'bx;
    bs_seen = 4'b0000; rnw_seen = 1'b0; bank_seen = 1'b0; bad_oe = 0; unstable = 0;
    req = 1'b1; req_write = w; req_addr = a; req_size = sz; req_wdata = wd;
    waitstate = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clock);
      #1;
      if (cs) n_cs++;
      if (as) begin
        if (n_as == 0) begin
          bs_seen = byte_selects; rnw_seen = rn_w; bank_seen = bank_addr;
        end else if (byte_selects !== bs_seen || rn_w !== rnw_seen || bank_addr !== bank_seen) begin
          unstable++;
        end
        if (data_oe !== w || (w && data_out !== wd)) bad_oe++;
        n_as++;
      end else if (data_oe !== 1'b0) begin
        bad_oe++;
      end
      if (ds) n_ds++;
      waitstate = (n_ds <= ws_high + 1);
      if (ack) begin
        lat = c;
        got_err = err;
        waitstate = 1'b0;
        break;
      end
    end
    if (!hold) req = 1'b0;
  endtask

  task automatic test_reset();
    if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++;
    if ({cs, as, ds} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {cs, as, ds}); end
    checks++;
    if ({data_oe, rn_w, bank_addr} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {data_oe, rn_w, bank_addr}); end
    checks++;
    if (byte_selects !== 4'b0000) begin failures++; $display("FAIL reset_bs got=%b exp=0000", byte_selects); end
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
    checks++;
  endtask

  task automatic test_long_read();
    int n_as, n_ds, n_cs, lat, bad_oe, unstable;
    logic e, rnw, bk;
    logic [3:0] bs;
    data_in = 32'hDEADBEEF;
    run_txn(1'b0, 24'h000000, 2'b00, 32'h0, 3, 1'b0, n_as, n_ds, n_cs, lat, e, bs, rnw, bk, bad_oe, unstable);
    if (lat !== 7) begin failures++; $display("FAIL long_read_latency got=%0d exp=7", lat); end
    checks++;
    if (n_as !== 6 || n_cs !== 6) begin failures++; $display("FAIL long_read_as_cs got=%0d/%0d exp=6/6", n_as, n_cs); end
    checks++;
    if (n_ds !== 5) begin failures++; $display("FAIL long_read_ds got=%0d exp=5", n_ds); end
    checks++;
    if (bs !== 4'b1111 || rnw !== 1'b0 || bk !== 1'b0) begin failures++; $display("FAIL long_read_ctl got=%b/%b/%b exp=1111/0/0", bs, rnw, bk); end
    checks++;
    if (rdata !== 32'hDEADBEEF || e !== 1'b0) begin failures++; $display("FAIL long_read_data got=%h err=%b exp=deadbeef err=0", rdata, e); end
    checks++;
    if (bad_oe !== 0 || unstable !== 0) begin failures++; $display("FAIL long_read_stable got=%0d/%0d exp=0/0", bad_oe, unstable); end
    checks++;
    idle(4);
  endtask

  task automatic test_word_write();
    int n_as, n_ds, n_cs, lat, bad_oe, unstable;
    logic e, rnw, bk;
    logic [3:0] bs;
    data_in = 32'h55555555;
    run_txn(1'b1, 24'h400002, 2'b10, 32'h12345678, 0, 1'b0, n_as, n_ds, n_cs, lat, e, bs, rnw, bk, bad_oe, unstable);
    if (lat !== 4) begin failures++; $display("FAIL word_write_latency got=%0d exp=4", lat); end
    checks++;
    if (bs !== 4'b0011 || rnw !== 1'b1 || bk !== 1'b1) begin failures++; $display("FAIL word_write_ctl got=%b/%b/%b exp=0011/1/1", bs, rnw, bk); end
    checks++;
    if (bad_oe !== 0 || unstable !== 0 || n_as !== 3) begin failures++; $display("FAIL word_write_oe got=%0d/%0d as=%0d exp=0/0 as=3", bad_oe, unstable, n_as); end
    checks++;
    if (e !== 1'b0 || rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL word_write_done got=err%b %h exp=err0 deadbeef", e, rdata); end
    checks++;
    idle(4);
  endtask

  task automatic test_byte_reads();
    logic [3:0] exp_bs [4];
    int n_as, n_ds, n_cs, lat, bad_oe, unstable;
    logic e, rnw, bk;
    logic [3:0] bs;
    exp_bs[0] = 4'b1000; exp_bs[1] = 4'b0100; exp_bs[2] = 4'b0010; exp_bs[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      data_in = 32'hA0A0A000 + 32'(i);
      run_txn(1'b0, 24'h000100 + 24'(i), 2'b01, 32'h0, 1, 1'b0, n_as, n_ds, n_cs, lat, e, bs, rnw, bk, bad_oe, unstable);
      if (bs !== exp_bs[i] || lat !== 5 || e !== 1'b0) begin
        failures++;
        $display("FAIL byte_read_%0d got=bs%b lat%0d err%b exp=bs%b lat5 err0", i, bs, lat, e, exp_bs[i]);
      end
      checks++;
      if (rdata !== 32'hA0A0A000 + 32'(i)) begin failures++; $display("FAIL byte_read_data_%0d got=%h exp=%h", i, rdata, 32'hA0A0A000 + 32'(i)); end
      checks++;
      idle(4);
    end
  endtask

  task automatic test_illegal();
    logic [1:0]  sizes [2];
    logic [23:0] addrs [2];
    int n_as, n_ds, n_cs, lat, bad_oe, unstable;
    logic e, rnw, bk;
    logic [3:0] bs;
    sizes[0] = 2'b10; addrs[0] = 24'h000001;
    sizes[1] = 2'b11; addrs[1] = 24'h000000;
    data_in = 32'h77777777;
    for (int i = 0; i < 2; i++) begin
      run_txn(1'b0, addrs[i], sizes[i], 32'h0, 0, 1'b0, n_as, n_ds, n_cs, lat, e, bs, rnw, bk, bad_oe, unstable);
      if (n_as !== 0 || n_cs !== 0 || n_ds !== 0) begin failures++; $display("FAIL illegal_strobes_%0d got=as%0d cs%0d exp=0", i, n_as, n_cs); end
      checks++;
      if (lat !== 1 || e !== 1'b1) begin failures++; $display("FAIL illegal_ack_%0d got=lat%0d err%b exp=lat1 err1", i, lat, e); end
      checks++;
      if (rdata !== 32'hA0A0A003) begin failures++; $display("FAIL illegal_rdata_%0d got=%h exp=a0a0a003", i, rdata); end
      checks++;
      idle(4);
    end
  endtask

  task automatic test_timeout();
    int n_as, n_ds, n_cs, lat, bad_oe, unstable;
    logic e, rnw, bk;
    logic [3:0] bs;
    data_in = 32'h99999999;
    run_txn(1'b0, 24'h000000, 2'b00, 32'h0, 100000, 1'b0, n_as, n_ds, n_cs, lat, e, bs, rnw, bk, bad_oe, unstable);
    if (n_ds !== 256 || n_as !== 257) begin failures++; $display("FAIL timeout_len got=ds%0d as%0d exp=ds256 as257", n_ds, n_as); end
    checks++;
    if (lat !== 258 || e !== 1'b1) begin failures++; $display("FAIL timeout_ack got=lat%0d err%b exp=lat258 err1", lat, e); end
    checks++;
    if (rdata !== 32'hA0A0A003) begin failures++; $display("FAIL timeout_rdata got=%h exp=a0a0a003", rdata); end
    checks++;
    idle(4);
  endtask

  task automatic test_back_to_back();
    int n_as, n_ds, n_cs, lat, bad_oe, unstable;
    int gap, dirty, lat2;
    bit found;
    logic e, rnw, bk;
    logic [3:0] bs;
    data_in = 32'h0BADF00D;
    run_txn(1'b0, 24'h000004, 2'b00, 32'h0, 0, 1'b1, n_as, n_ds, n_cs, lat, e, bs, rnw, bk, bad_oe, unstable);
    if (lat !== 4 || e !== 1'b0) begin failures++; $display("FAIL b2b_first got=lat%0d err%b exp=lat4 err0", lat, e); end
    checks++;
    gap = 0; dirty = 0; found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      if (as) begin found = 1'b1; break; end
      if (cs || ds || data_oe || ack || byte_selects !== 4'b0000) dirty++;
      gap++;
    end
    req = 1'b0;
    if (!found || gap !== 2 || dirty !== 0) begin failures++; $display("FAIL b2b_gap got=%0d found%0d dirty%0d exp=2 found1 dirty0", gap, found, dirty); end
    checks++;
    lat2 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock);
      #1;
      if (ack) begin lat2 = c; break; end
    end
    if (lat2 !== 3) begin failures++; $display("FAIL b2b_second got=%0d exp=3", lat2); end
    checks++;
    idle(4);
  endtask

  task automatic test_reset_mid();
    int n_ds, stray;
    n_ds = 0; stray = 0;
    data_in = 32'h13579BDF;
    req = 1'b1; req_write = 1'b0; req_addr = 24'h000000; req_size = 2'b00; waitstate = 1'b1;
    for (int c = 0; c < 20 && n_ds < 3; c++) begin
      @(posedge clock);
      #1;
      if (ds) n_ds++;
    end
    if (n_ds !== 3) begin failures++; $display("FAIL midreset_setup got=%0d exp=3", n_ds); end
    checks++;
    reset = 1'b1;
    @(posedge clock);
    #1;
    if ({cs, as, ds, data_oe, ack} !== 5'b00000) begin failures++; $display("FAIL midreset_drop got=%b exp=00000", {cs, as, ds, data_oe, ack}); end
    checks++;
    req = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      if (ack || as || cs) stray++;
    end
    if (stray !== 0 || rdata !== 32'h0) begin failures++; $display("FAIL midreset_after got=stray%0d rdata%h exp=0 00000000", stray, rdata); end
    checks++;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_wdata = '0; waitstate = 1'b0; data_in = '0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    idle(2);
    test_long_read();
    test_word_write();
    test_byte_reads();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
